// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO special-register unit.
// Stages EX-stage HI/LO writes through M and W registers before committing
// them to the architectural HI/LO pair, and supplies the read values the
// execute-stage ALUs consume.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ex_we, ex_hi/lo    EX-stage write request and HI/LO values
//   stall              hold M, inject a bubble into W
//   flush              discard the M-stage entry
//   hi, lo             read values to the ALUs (combinational)
//   arch_hi, arch_lo   committed HI/LO registers
//   hazard             read would be stale, pipeline must stall (combinational)
//
// Configuration macro: HILO_BYPASS_EN
//   defined   : hi/lo forwarded from M > W > arch, hazard tied 0
//   undefined : hi/lo read straight from arch, hazard = m_valid | w_valid
module hilo_unit #(
    localparam int unsigned WORD_BUS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_we,
    input  logic [WORD_BUS-1:0] ex_hi,
    input  logic [WORD_BUS-1:0] ex_lo,
    input  logic                stall,
    input  logic                flush,
    output logic [WORD_BUS-1:0] hi,
    output logic [WORD_BUS-1:0] lo,
    output logic [WORD_BUS-1:0] arch_hi,
    output logic [WORD_BUS-1:0] arch_lo,
    output logic                hazard
);

    logic                m_valid;
    logic [WORD_BUS-1:0] m_hi;
    logic [WORD_BUS-1:0] m_lo;
    logic                w_valid;
    logic [WORD_BUS-1:0] w_hi;
    logic [WORD_BUS-1:0] w_lo;

    // M stage: flush beats stall beats normal capture.
    // On flush only the valid bit is cleared; the stale data is never read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_hi    <= '0;
            m_lo    <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!stall) begin
            m_valid <= ex_we;
            m_hi    <= ex_hi;
            m_lo    <= ex_lo;
        end
    end

    // W stage: a stall (alone or together with flush) leaves M in place or
    // discards it, so W receives a bubble; otherwise W takes M's old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
            w_hi    <= '0;
            w_lo    <= '0;
        end else begin
            w_valid <= m_valid & ~stall;
            w_hi    <= m_hi;
            w_lo    <= m_lo;
        end
    end

    // Commit: a valid W entry always lands, independent of stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch_hi <= '0;
            arch_lo <= '0;
        end else if (w_valid) begin
            arch_hi <= w_hi;
            arch_lo <= w_lo;
        end
    end

`ifdef HILO_BYPASS_EN
    // Newest in-flight value wins; never sourced from ex_* to avoid a
    // combinational loop back through the ALU.
    always_comb begin
        hi     = arch_hi;
        lo     = arch_lo;
        hazard = 1'b0;
        if (m_valid) begin
            hi = m_hi;
            lo = m_lo;
        end else if (w_valid) begin
            hi = w_hi;
            lo = w_lo;
        end
    end
`else
    // Readers see only committed state and are held off while a write is
    // in flight.
    always_comb begin
        hi     = arch_hi;
        lo     = arch_lo;
        hazard = m_valid | w_valid;
    end
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: a driver applies directed vectors at the
// falling edge and queues the hand-computed outputs expected after the next
// rising edge; a monitor pops and compares just after each rising edge.
module tb_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_we;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        stall;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] arch_hi;
    logic [31:0] arch_lo;
    logic        hazard;

    hilo_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ex_we   (ex_we),
        .ex_hi   (ex_hi),
        .ex_lo   (ex_lo),
        .stall   (stall),
        .flush   (flush),
        .hi      (hi),
        .lo      (lo),
        .arch_hi (arch_hi),
        .arch_lo (arch_lo),
        .hazard  (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fhi/flo: forwarded read values; ahi/alo: committed values;
    // hz: hazard in the non-forwarding build. All after the coming edge.
    typedef struct {
        logic        rst_n;
        logic        we;
        logic [31:0] h;
        logic [31:0] l;
        logic        stall;
        logic        flush;
        logic [31:0] fhi;
        logic [31:0] flo;
        logic [31:0] ahi;
        logic [31:0] alo;
        logic        hz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ahi;
        logic [31:0] alo;
        logic        hz;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_idx  = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got 0x%08h, expected 0x%08h", name, idx, act, req);
        end
    endtask

    task automatic add(input logic r, input logic we, input logic [31:0] h,
                       input logic [31:0] l, input logic st, input logic fl,
                       input logic [31:0] fhi, input logic [31:0] flo,
                       input logic [31:0] ahi, input logic [31:0] alo, input logic hz);
        vecs.push_back('{r, we, h, l, st, fl, fhi, flo, ahi, alo, hz});
    endtask

    task automatic idle_vec(input logic [31:0] fhi, input logic [31:0] flo,
                            input logic [31:0] ahi, input logic [31:0] alo,
                            input logic hz);
        add(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, fhi, flo, ahi, alo, hz);
    endtask

    task automatic reset_vec();
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Drive every queued vector, one per cycle, and queue its expectation.
    task automatic run_vecs();
        vec_t v;
        exp_t e;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            @(negedge clk);
            rst_n = v.rst_n;
            ex_we = v.we;
            ex_hi = v.h;
            ex_lo = v.l;
            stall = v.stall;
            flush = v.flush;
`ifdef HILO_BYPASS_EN
            e.hi = v.fhi;
            e.lo = v.flo;
            e.hz = 1'b0;
`else
            e.hi = v.ahi;
            e.lo = v.alo;
            e.hz = v.hz;
`endif
            e.ahi = v.ahi;
            e.alo = v.alo;
            e.idx = vec_idx;
            vec_idx++;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every rising edge, compare outputs with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("hi", mon_e.idx, hi, mon_e.hi);
                check("lo", mon_e.idx, lo, mon_e.lo);
                check("arch_hi", mon_e.idx, arch_hi, mon_e.ahi);
                check("arch_lo", mon_e.idx, arch_lo, mon_e.alo);
                check("hazard", mon_e.idx, 32'(hazard), 32'(mon_e.hz));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ex_we = 1'b0;
        ex_hi = '0;
        ex_lo = '0;
        stall = 1'b0;
        flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", -1, hi, 32'h0);
        check("rst_lo", -1, lo, 32'h0);
        check("rst_arch_hi", -1, arch_hi, 32'h0);
        check("rst_arch_lo", -1, arch_lo, 32'h0);
        check("rst_hazard", -1, 32'(hazard), 32'h0);

        // Release and idle for 5 cycles.
        for (int i = 0; i < 5; i++) idle_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Single write: visible from M next cycle, committed on the 3rd edge.
        add(1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0,
            32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b1);
        idle_vec(32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b1);
        idle_vec(32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        idle_vec(32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);

        // Back-to-back writes: 3/4 shadows 1/2; arch passes through 1/2.
        add(1'b1, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0,
            32'd1, 32'd2, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        add(1'b1, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0,
            32'd3, 32'd4, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        idle_vec(32'd3, 32'd4, 32'd1, 32'd2, 1'b1);
        idle_vec(32'd3, 32'd4, 32'd3, 32'd4, 1'b0);
        idle_vec(32'd3, 32'd4, 32'd3, 32'd4, 1'b0);

        // Flush on the edge that would capture the write: nothing commits.
        reset_vec();
        add(1'b1, 1'b1, 32'hAA, 32'hBB, 1'b0, 1'b1,
            32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) idle_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Stall and flush together: M cleared and W gets a bubble.
        reset_vec();
        add(1'b1, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0,
            32'h11, 32'h22, 32'h0, 32'h0, 1'b1);
        add(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
            32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) idle_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Stall held 3 cycles: M forwarded throughout, commit 2 edges later.
        reset_vec();
        add(1'b1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0,
            32'd5, 32'd6, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0,
                32'd5, 32'd6, 32'h0, 32'h0, 1'b1);
        idle_vec(32'd5, 32'd6, 32'h0, 32'h0, 1'b1);
        idle_vec(32'd5, 32'd6, 32'd5, 32'd6, 1'b0);
        idle_vec(32'd5, 32'd6, 32'd5, 32'd6, 1'b0);

        // Write 7/8, then reset asynchronously while it sits in M.
        add(1'b1, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0,
            32'd7, 32'd8, 32'd5, 32'd6, 1'b1);
        run_vecs();

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ex_we = 1'b0;
        #1;
        check("async_rst_hi", -2, hi, 32'h0);
        check("async_rst_lo", -2, lo, 32'h0);
        check("async_rst_arch_hi", -2, arch_hi, 32'h0);
        check("async_rst_arch_lo", -2, arch_lo, 32'h0);
        check("async_rst_hazard", -2, 32'(hazard), 32'h0);

        // After release the lost 7/8 entry must never commit.
        for (int i = 0; i < 4; i++) idle_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        run_vecs();

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
